// File: rtl/adc_capture_pkg.sv
// Shared widths, state encoding and accumulator sizing for the ADC capture controller.
package adc_capture_pkg;

    localparam int DATA_W_DEF   = 12;
    localparam int OUT_W_DEF    = 8;
    localparam int ADDR_W_DEF   = 5;
    localparam int AVG_LOG2_DEF = 2;

    // Sized to hold 2^AVG_LOG2 full-scale samples without overflow.
    function automatic int acc_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

    localparam int ACC_W = acc_width(DATA_W_DEF, AVG_LOG2_DEF);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAPTURE   = 2'd1,
        ST_DONE      = 2'd2,
        ST_WAIT_TRIG = 2'd3
    } state_e;

endpackage

// File: rtl/adc_capture_ctrl_avg.sv
// Group averager: sums 2^AVG_LOG2 accepted samples, flags the last one and
// presents the truncated average combinationally alongside that flag.
module adc_avg_accum
    import adc_capture_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [OUT_W-1:0]  avg_o,
    output logic              avg_valid_o
);

    localparam int AW    = acc_width(DATA_W, AVG_LOG2);
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] GROUP_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [AW-1:0]    acc_q, acc_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;

    assign sum  = acc_q + AW'(sample_i);
    assign last = (cnt_q == GROUP_LAST);

    // Top bits of (sum >> AVG_LOG2) taken directly; plain truncation.
    assign avg_o       = sum[AW-1 -: OUT_W];
    assign avg_valid_o = accept_i && last;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept_i) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: averages sample groups and writes one byte per group to RAM.
// Define ADC_CAPTURE_TRIG_EN to add a rising-level trigger (iTRIG_LEVEL) after arm.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OUT_W    = OUT_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iSAMPLE,
    input  logic              iSAMPLE_VALID,
    input  logic              iARM,
`ifdef ADC_CAPTURE_TRIG_EN
    input  logic [DATA_W-1:0] iTRIG_LEVEL,
`endif
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [OUT_W-1:0]  oWR_DATA,
    output logic              oWREN,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [ADDR_W:0]   oWORDS,
    output state_e            oDBG_STATE
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [OUT_W-1:0]  wr_data_q, wr_data_d, avg;
    logic              wren_q, wren_d, avg_valid;
    logic              accept, arm_clr, final_wr;

    assign final_wr = wren_q && (addr_q == ADDR_LAST);
    assign arm_clr  = iARM && ((state_q == ST_IDLE) || (state_q == ST_DONE));

`ifdef ADC_CAPTURE_TRIG_EN
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              trig_hit;

    assign trig_hit = (prev_q < iTRIG_LEVEL) && (iSAMPLE >= iTRIG_LEVEL);
    assign accept   = iSAMPLE_VALID &&
                      (((state_q == ST_CAPTURE) && !final_wr) ||
                       ((state_q == ST_WAIT_TRIG) && trig_hit));
`else
    // Samples landing in the final write cycle belong to a group that is discarded.
    assign accept   = iSAMPLE_VALID && (state_q == ST_CAPTURE) && !final_wr;
`endif

    adc_avg_accum #(
        .DATA_W  (DATA_W),
        .OUT_W   (OUT_W),
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .clk_i      (iCLK),
        .rst_i      (iRST),
        .clear_i    (arm_clr),
        .accept_i   (accept),
        .sample_i   (iSAMPLE),
        .avg_o      (avg),
        .avg_valid_o(avg_valid)
    );

    assign wren_d    = avg_valid;
    assign wr_data_d = avg_valid ? avg : wr_data_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        words_d = words_q;
`ifdef ADC_CAPTURE_TRIG_EN
        prev_d  = prev_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (iARM) begin
                    addr_d  = '0;
                    words_d = '0;
`ifdef ADC_CAPTURE_TRIG_EN
                    prev_d  = '1;
                    state_d = ST_WAIT_TRIG;
`else
                    state_d = ST_CAPTURE;
`endif
                end
            end
            ST_CAPTURE: begin
                // Address/word count advance the cycle after each write strobe.
                if (wren_q) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    words_d = words_q + (ADDR_W + 1)'(1);
                    if (final_wr) state_d = ST_DONE;
                end
            end
            ST_WAIT_TRIG: begin
`ifdef ADC_CAPTURE_TRIG_EN
                if (iSAMPLE_VALID) begin
                    if (trig_hit) state_d = ST_CAPTURE;
                    else          prev_d  = iSAMPLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            words_q   <= '0;
            wr_data_q <= '0;
            wren_q    <= 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
            prev_q    <= '1;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
            wr_data_q <= wr_data_d;
            wren_q    <= wren_d;
`ifdef ADC_CAPTURE_TRIG_EN
            prev_q    <= prev_d;
`endif
        end
    end

    assign oWR_ADDR   = addr_q;
    assign oWR_DATA   = wr_data_q;
    assign oWREN      = wren_q;
    assign oWORDS     = words_q;
    assign oBUSY      = (state_q == ST_CAPTURE) || (state_q == ST_WAIT_TRIG);
    assign oDONE      = (state_q == ST_DONE);
    assign oDBG_STATE = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed-plus-random bench for adc_capture_ctrl against a sample-list reference model.
module tb_adc_capture_ctrl;
    import adc_capture_pkg::*;

    localparam int DATA_W   = 12;
    localparam int OUT_W    = 8;
    localparam int ADDR_W   = 5;
    localparam int AVG_LOG2 = 2;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int GROUP    = 1 << AVG_LOG2;
    localparam int W        = ADDR_W + OUT_W;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic [DATA_W-1:0] iSAMPLE;
    logic              iSAMPLE_VALID;
    logic              iARM;
    logic [DATA_W-1:0] trig_level;
    logic [ADDR_W-1:0] oWR_ADDR;
    logic [OUT_W-1:0]  oWR_DATA;
    logic              oWREN, oBUSY, oDONE;
    logic [ADDR_W:0]   oWORDS;
    state_e            oDBG_STATE;

    always #5 iCLK = ~iCLK;

    adc_capture_ctrl dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iSAMPLE      (iSAMPLE),
        .iSAMPLE_VALID(iSAMPLE_VALID),
        .iARM         (iARM),
`ifdef ADC_CAPTURE_TRIG_EN
        .iTRIG_LEVEL  (trig_level),
`endif
        .oWR_ADDR     (oWR_ADDR),
        .oWR_DATA     (oWR_DATA),
        .oWREN        (oWREN),
        .oBUSY        (oBUSY),
        .oDONE        (oDONE),
        .oWORDS       (oWORDS),
        .oDBG_STATE   (oDBG_STATE)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           exp_cyc_q[$];
    int           got_cyc_q[$];

    always @(posedge iCLK) cyc_n++;

    always @(negedge iCLK) begin
        if (oWREN === 1'b1) begin
            got_q.push_back({oWR_ADDR, oWR_DATA});
            got_cyc_q.push_back(cyc_n);
        end
    end

    // Reference model: capture = list of accepted samples, one write per full group.
    bit m_cap, m_wait;
    int m_prev, m_addr, m_words;
    int m_grp[$];

    task automatic model_reset();
        m_cap = 0; m_wait = 0; m_addr = 0; m_words = 0; m_prev = 0;
        m_grp.delete();
    endtask

    task automatic model_arm();
        if (!m_cap && !m_wait) begin
            m_addr = 0; m_words = 0;
            m_grp.delete();
`ifdef ADC_CAPTURE_TRIG_EN
            m_wait = 1; m_prev = (1 << DATA_W) - 1;
`else
            m_cap = 1;
`endif
        end
    endtask

    task automatic model_sample(input int s);
        int sum;
        if (m_wait) begin
            if (m_prev < int'(trig_level) && s >= int'(trig_level)) begin
                m_wait = 0; m_cap = 1;
            end else begin
                m_prev = s;
            end
        end
        if (m_cap) begin
            m_grp.push_back(s);
            if (m_grp.size() == GROUP) begin
                sum = 0;
                foreach (m_grp[i]) sum += m_grp[i];
                exp_q.push_back({ADDR_W'(m_addr % DEPTH), OUT_W'((sum / GROUP) / (1 << (DATA_W - OUT_W)))});
                exp_cyc_q.push_back(cyc_n + 1);
                m_addr++; m_words++;
                m_grp.delete();
                if (m_addr == DEPTH) m_cap = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input bit v, input logic [DATA_W-1:0] s, input bit a);
        iSAMPLE_VALID = v; iSAMPLE = s; iARM = a;
        if (v) model_sample(int'(s));
        if (a) model_arm();
        @(posedge iCLK); #1;
        iSAMPLE_VALID = 1'b0; iARM = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0);
    endtask

    // With the trigger build, a primed low sample makes the next nonzero sample fire.
    task automatic arm(input bit prime);
`ifdef ADC_CAPTURE_TRIG_EN
        if (prime) trig_level = 12'h001;
`endif
        drive(1'b0, '0, 1'b1);
`ifdef ADC_CAPTURE_TRIG_EN
        if (prime) drive(1'b1, 12'h000, 1'b0);
`endif
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check({tag, "_write_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr_data"}, got_q.pop_front(), exp_q.pop_front());
            check({tag, "_latency"}, got_cyc_q.pop_front(), exp_cyc_q.pop_front());
        end
        got_q.delete(); exp_q.delete(); got_cyc_q.delete(); exp_cyc_q.delete();
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},  oDONE,    1);
        check({tag, "_busy"},  oBUSY,    0);
        check({tag, "_words"}, oWORDS,   m_words);
        check({tag, "_addr"},  oWR_ADDR, 0);
    endtask

    initial begin
        iRST = 1'b1; iARM = 1'b0; iSAMPLE_VALID = 1'b0; iSAMPLE = '0;
        trig_level = 12'h001;
        model_reset();
        repeat (2) @(posedge iCLK);
        #1;
        check("rst_wren",  oWREN,    0);
        check("rst_addr",  oWR_ADDR, 0);
        check("rst_data",  oWR_DATA, 0);
        check("rst_busy",  oBUSY,    0);
        check("rst_done",  oDONE,    0);
        check("rst_words", oWORDS,   0);
        iRST = 1'b0;
        idle(2);

        // Full capture of constant 0xABC, one sample every 4 cycles, stray arm mid-run.
        arm(1'b1);
        check("arm_busy", oBUSY, 1);
        for (int i = 0; i < DEPTH * GROUP; i++) begin
            drive(1'b1, 12'hABC, 1'b0);
            drive(1'b0, '0, (i == 40));
            idle(2);
        end
        idle(3);
        compare_writes("const");
        check_done("const");

        // Samples in DONE are ignored.
        for (int i = 0; i < 8; i++) drive(1'b1, DATA_W'($urandom_range(0, 4095)), 1'b0);
        idle(2);
        compare_writes("done_ignore");
        check("done_hold", oDONE, 1);

        // Truncated average of 1,0,2,0xFFF = 0x1002>>2 = 0x400 -> 0x40.
        arm(1'b1);
        drive(1'b1, 12'h001, 1'b0);
        drive(1'b1, 12'h000, 1'b0);
        drive(1'b1, 12'h002, 1'b0);
        drive(1'b1, 12'hFFF, 1'b0);
        check("trunc_wren", oWREN,    1);
        check("trunc_data", oWR_DATA, 8'h40);
        check("trunc_addr", oWR_ADDR, 0);
        idle(1);
        check("post_wr_addr",  oWR_ADDR, 1);
        check("post_wr_words", oWORDS,   1);
        check("post_wr_wren",  oWREN,    0);

        // Back-to-back ramp finishes the same capture.
        for (int i = 0; i < (DEPTH - 1) * GROUP + 2; i++)
            drive(1'b1, DATA_W'((i * 37) % 4096), 1'b0);
        idle(3);
        compare_writes("ramp");
        check_done("ramp");

        // Random values with random gaps.
        arm(1'b1);
        for (int i = 0; i < DEPTH * GROUP + 12; i++) begin
            drive(1'b1, DATA_W'($urandom_range(1, 4095)), 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(3);
        compare_writes("rand");
        check_done("rand");

        // Asynchronous reset right after the 10th write.
        arm(1'b1);
        for (int i = 0; i < 10 * GROUP; i++) drive(1'b1, DATA_W'($urandom_range(1, 4095)), 1'b0);
        check("tenth_wren", oWREN, 1);
        #5;
        iRST = 1'b1;
        #1;
        check("async_wren",  oWREN,    0);
        check("async_addr",  oWR_ADDR, 0);
        check("async_data",  oWR_DATA, 0);
        check("async_busy",  oBUSY,    0);
        check("async_words", oWORDS,   0);
        compare_writes("pre_reset");
        model_reset();
        @(posedge iCLK); #1;
        iRST = 1'b0;
        for (int i = 0; i < 6; i++) drive(1'b1, DATA_W'($urandom_range(1, 4095)), 1'b0);
        idle(2);
        compare_writes("idle_ignore");
        arm(1'b1);
        for (int i = 0; i < GROUP; i++) drive(1'b1, DATA_W'($urandom_range(1, 4095)), 1'b0);
        idle(2);
        compare_writes("rearm");
        check("rearm_words", oWORDS,   m_words);
        check("rearm_addr",  oWR_ADDR, m_addr);

`ifdef ADC_CAPTURE_TRIG_EN
        iRST = 1'b1;
        model_reset();
        @(posedge iCLK); #1;
        iRST = 1'b0;
        trig_level = 12'h800;
        arm(1'b0);
        drive(1'b1, 12'h900, 1'b0);
        check("trig_first_no_fire", 32'(oDBG_STATE), 32'(ST_WAIT_TRIG));
        drive(1'b1, 12'h700, 1'b0);
        drive(1'b1, 12'h7FF, 1'b0);
        check("trig_below_no_fire", 32'(oDBG_STATE), 32'(ST_WAIT_TRIG));
        drive(1'b1, 12'h800, 1'b0);
        check("trig_fire", 32'(oDBG_STATE), 32'(ST_CAPTURE));
        for (int i = 0; i < GROUP - 1; i++) drive(1'b1, DATA_W'($urandom_range(0, 4095)), 1'b0);
        idle(2);
        compare_writes("trig");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
